serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Nibble-serial W-bit adder controller. It time-multiplexes one 4-bit ripple-carry adder (four_bit_adder) across the NIBBLES slices of a wide operand, least-significant slice first. Between cycles the carry is held in a register.
Input side is a valid/ready handshake; output side is also valid/ready. The block sits between operand producers and result consumers that do not need a full-width combinational adder.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (min 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operands present
in_ready  output  1  controller can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in of slice 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result
cout  output  1  carry-out of top slice

Behaviour:
- Single clock; reset is asynchronous, active-high.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0. Internally: slice index=0, carry reg=0, operand regs=0.
- IDLE: in_ready=1.
  - in_valid=1 at an edge latches a, b, cin (carry reg <= cin), sets index=0, and goes to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle the adder sees a_reg[4i+3:4i], b_reg[4i+3:4i] and carry reg.
  - At the edge: sum[4i+3:4i] <= s, carry reg <= adder cout, index++.
  - When index==NIBBLES-1 at the edge: cout <= adder cout, go to DONE.
- DONE: out_valid=1, in_ready=0; sum and cout are held stable.
  - out_ready=1 at an edge returns to IDLE; out_valid drops next cycle.
  - No new operand is accepted in the same cycle (no bypass).
- Latency: acceptance edge E; out_valid is high from edge E+NIBBLES. Throughput is one result per NIBBLES+2 cycles minimum.
- in_valid while not in IDLE is ignored; operands are not captured.
- sum updates slice-by-slice during RUN. Consumers use sum only when out_valid=1.
- NIBBLES=1: RUN lasts one cycle.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE; all outputs go to reset values without waiting for a clock edge.
  - The partial result is discarded.
- Arithmetic is unsigned modulo 2^W; cout is bit W of a+b+cin.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: adds input port sub (1 bit), latched with the operands.
  - sub=1: each slice uses ~b slice; the carry reg is initialised to 1 and cin is ignored.
  - Result is a-b mod 2^W; cout=1 means no borrow (a>=b).
  - sub=0 behaves exactly as without the macro.
- Undefined: sub port absent; addition only.

Decomposition:
- Shared package/include serial_adder_pkg:
  - NIBBLE_W=4.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Index width helper (clog2 of NIBBLES, min 1).
- One sub-module: the existing four_bit_adder, instantiated once with scalar bit ports driven from the selected slice.
- FSM, operand registers, carry register and slice mux live in serial_adder_ctrl.

Test Plan:
1. NIBBLES=4, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 slices via the carry reg).
3. a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0.
4. Backpressure:
   - out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0, a new in_valid with a=0xAAAA is ignored.
   - Then out_ready=1 -> IDLE; the next in_valid is accepted with fresh operands.
5. rst pulsed during the 2nd RUN cycle -> out_valid=0, sum=0, cout=0 immediately; in_ready=1 after release; next transaction 0x0001+0x0001 gives sum=0x0002.
6. SERIAL_ADD_SUB_EN:
   - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
   - a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants, state encoding and index-width helper for the nibble-serial adder.
package serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_four_bit_adder.sv
// 4-bit ripple-carry adder with scalar bit ports; one slice of the serial datapath.
module four_bit_adder (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic cin,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic cout
);

    logic w_c1, w_c2, w_c3;

    assign s0   = a0 ^ b0 ^ cin;
    assign w_c1 = (a0 & b0) | (cin  & (a0 ^ b0));
    assign s1   = a1 ^ b1 ^ w_c1;
    assign w_c2 = (a1 & b1) | (w_c1 & (a1 ^ b1));
    assign s2   = a2 ^ b2 ^ w_c2;
    assign w_c3 = (a2 & b2) | (w_c2 & (a2 ^ b2));
    assign s3   = a3 ^ b3 ^ w_c3;
    assign cout = (a3 & b3) | (w_c3 & (a3 ^ b3));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial W-bit adder controller with valid/ready on both sides.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for a-b (two's complement).
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one nibble per cycle through the shared adder, LSB slice first
// DONE  | out_valid=1, result held until out_ready
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    input  logic                      cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                      sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NIBBLES-1:0]      sum,
    output logic                      cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_w(NIBBLES);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_sub;

    logic [NIBBLE_W-1:0] w_a_sl;
    logic [NIBBLE_W-1:0] w_b_sl;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_sub_in;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_sl = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_sl = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
        // Subtraction feeds the inverted B slice; the +1 comes from the carry init.
        if (r_sub) begin
            w_b_sl = ~w_b_sl;
        end
    end

    four_bit_adder u_adder (
        .a0   (w_a_sl[0]),
        .a1   (w_a_sl[1]),
        .a2   (w_a_sl[2]),
        .a3   (w_a_sl[3]),
        .b0   (w_b_sl[0]),
        .b1   (w_b_sl[1]),
        .b2   (w_b_sl[2]),
        .b3   (w_b_sl[3]),
        .cin  (r_carry),
        .s0   (w_s[0]),
        .s1   (w_s[1]),
        .s2   (w_s[2]),
        .s3   (w_s[3]),
        .cout (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sub       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_sub      <= w_sub_in;
                        r_carry    <= w_sub_in ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_s;
                        end
                    end
                    r_carry <= w_co;
                    r_idx   <= r_idx + IW'(1);
                    if (r_idx == IW'(NIBBLES - 1)) begin
                        r_cout      <= w_co;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No bypass: the IDLE cycle after release is always spent.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (NIBBLES=4); covers sub mode when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
`ifdef SERIAL_ADD_SUB_EN
    logic        sub_i;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_o;
    logic        cout_o;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum_o),
        .cout      (cout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, let the accept edge happen, then count edges until out_valid.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb,
                           input logic tc, output int lat);
        a_i      = ta;
        b_i      = tb;
        cin_i    = tc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (sum_o !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum_o); end
        checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout_o); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic [15:0] es [3];
        logic        ec [3];
        int lat;
        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0; es[0] = 16'h5555; ec[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0; es[1] = 16'h0000; ec[1] = 1'b1;
        va[2] = 16'h0FFF; vb[2] = 16'h0000; vc[2] = 1'b1; es[2] = 16'h1000; ec[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add%0d_ready_before got=%b exp=1", k, in_ready); end
            run_txn(va[k], vb[k], vc[k], lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency got=%0d exp=4", k, lat); end
            checks++; if (sum_o !== es[k]) begin errors++; $display("FAIL add%0d_sum got=%h exp=%h", k, sum_o, es[k]); end
            checks++; if (cout_o !== ec[k]) begin errors++; $display("FAIL add%0d_cout got=%b exp=%b", k, cout_o, ec[k]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add%0d_ready_done got=%b exp=0", k, in_ready); end
            release_result();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add%0d_valid_drop got=%b exp=0", k, out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add%0d_ready_back got=%b exp=1", k, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_txn(16'h1111, 16'h2222, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        a_i      = 16'hAAAA;
        b_i      = 16'h0000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (sum_o !== 16'h3333) begin errors++; $display("FAIL bp_sum_hold%0d got=%h exp=3333", k, sum_o); end
            checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL bp_cout_hold%0d got=%b exp=0", k, cout_o); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold%0d got=%b exp=1", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold%0d got=%b exp=0", k, in_ready); end
        end
        in_valid = 1'b0;
        release_result();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b exp=1", in_ready); end
        run_txn(16'h0101, 16'h0202, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
        checks++; if (sum_o !== 16'h0303) begin errors++; $display("FAIL bp_next_sum got=%h exp=0303", sum_o); end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a_i      = 16'h1234;
        b_i      = 16'h4321;
        cin_i    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (sum_o[3:0] !== 4'h5) begin errors++; $display("FAIL rst_partial got=%h exp=5", sum_o[3:0]); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (sum_o !== 16'h0000) begin errors++; $display("FAIL rst_mid_sum got=%h exp=0000", sum_o); end
        checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL rst_mid_cout got=%b exp=0", cout_o); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        run_txn(16'h0001, 16'h0001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_next_latency got=%0d exp=4", lat); end
        checks++; if (sum_o !== 16'h0002) begin errors++; $display("FAIL rst_next_sum got=%h exp=0002", sum_o); end
        checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL rst_next_cout got=%b exp=0", cout_o); end
        release_result();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat;
        sub_i = 1'b1;
        run_txn(16'h0005, 16'h0007, 1'b0, lat);
        checks++; if (sum_o !== 16'hFFFE) begin errors++; $display("FAIL sub_neg_sum got=%h exp=fffe", sum_o); end
        checks++; if (cout_o !== 1'b0) begin errors++; $display("FAIL sub_neg_cout got=%b exp=0", cout_o); end
        release_result();
        run_txn(16'h0007, 16'h0005, 1'b1, lat);
        checks++; if (sum_o !== 16'h0002) begin errors++; $display("FAIL sub_pos_sum got=%h exp=0002", sum_o); end
        checks++; if (cout_o !== 1'b1) begin errors++; $display("FAIL sub_pos_cout got=%b exp=1", cout_o); end
        release_result();
        sub_i = 1'b0;
        run_txn(16'h0007, 16'h0005, 1'b0, lat);
        checks++; if (sum_o !== 16'h000C) begin errors++; $display("FAIL sub_off_sum got=%h exp=000c", sum_o); end
        release_result();
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        cin_i     = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_i     = 1'b0;
`endif
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
